// File: rtl/ctl_pkg.sv
// ============================================================================
// Module   : ctl_pkg
// Purpose  : Shared state, mux-select and opcode encodings for the multicycle FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

package ctl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECUTER = 4'd6,
        EXECUTEI = 4'd7,
        ALUWB    = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [1:0] SRCA_RN    = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_RM    = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;

    // Moore control vector; fetch/decode flags let the top apply input gating
    typedef struct packed {
        logic       mem_req;
        logic       mem_w;
        logic       adr_src;
        logic       fetch;
        logic       decode;
        logic       reg_w;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] result_src;
        logic       alu_op;
        logic       branch;
    } ctl_t;

endpackage

`default_nettype wire

// File: rtl/main_fsm_outputs.sv
// ============================================================================
// Module   : main_fsm_outputs
// Purpose  : Combinational state -> control-vector lookup for the main FSM
// Revision : 1.0
// ============================================================================
`default_nettype none

module main_fsm_outputs
    import ctl_pkg::*;
(
    input  logic [3:0] state,
    output ctl_t       ctl
);

    always_comb begin
        ctl = '0;
        case (state)
            FETCH: begin
                ctl.mem_req    = 1'b1;
                ctl.fetch      = 1'b1;
                ctl.alu_src_a  = SRCA_PC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
            end
            DECODE: begin
                ctl.decode     = 1'b1;
                ctl.alu_src_a  = SRCA_PC;
                ctl.alu_src_b  = SRCB_FOUR;
                ctl.result_src = RES_ALU;
            end
            MEMADR: begin
                ctl.alu_src_a = SRCA_RN;
                ctl.alu_src_b = SRCB_IMM;
            end
            MEMREAD: begin
                ctl.mem_req    = 1'b1;
                ctl.adr_src    = 1'b1;
                ctl.result_src = RES_ALUOUT;
            end
            MEMWB: begin
                ctl.result_src = RES_RDATA;
                ctl.reg_w      = 1'b1;
            end
            MEMWRITE: begin
                ctl.mem_req    = 1'b1;
                ctl.mem_w      = 1'b1;
                ctl.adr_src    = 1'b1;
                ctl.result_src = RES_ALUOUT;
            end
            EXECUTER: begin
                ctl.alu_src_a = SRCA_RN;
                ctl.alu_src_b = SRCB_RM;
                ctl.alu_op    = 1'b1;
            end
            EXECUTEI: begin
                ctl.alu_src_a = SRCA_RN;
                ctl.alu_src_b = SRCB_IMM;
                ctl.alu_op    = 1'b1;
            end
            ALUWB: begin
                ctl.result_src = RES_ALUOUT;
                ctl.reg_w      = 1'b1;
            end
            BRANCH: begin
                ctl.alu_src_a  = SRCA_RN;
                ctl.alu_src_b  = SRCB_IMM;
                ctl.result_src = RES_ALU;
                ctl.branch     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_main_fsm.sv
// ============================================================================
// Module   : multicycle_main_fsm
// Purpose  : Multicycle ARM main control FSM with memory request/ready handshake
// Revision : 1.0
// ============================================================================
`default_nettype none

module multicycle_main_fsm
    import ctl_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] op,
    input  logic [5:0] funct,
    input  logic       no_write,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_w,
    output logic       adr_src,
    output logic       ir_write,
    output logic       next_pc,
    output logic       reg_w,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] result_src,
    output logic       alu_op,
    output logic       branch,
    output logic       illegal,
    output logic [3:0] state
);

    logic [3:0] r_state;
    logic [3:0] w_next_state;
    ctl_t       w_ctl;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = FETCH;
        case (r_state)
            FETCH:    w_next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (op)
                    OP_DP:   w_next_state = funct[5] ? EXECUTEI : EXECUTER;
                    OP_MEM:  w_next_state = MEMADR;
                    OP_BR:   w_next_state = BRANCH;
                    default: w_next_state = FETCH;
                endcase
            end
            MEMADR:   w_next_state = funct[0] ? MEMREAD : MEMWRITE;
            MEMREAD:  w_next_state = mem_ready ? MEMWB : MEMREAD;
            MEMWB:    w_next_state = FETCH;
            MEMWRITE: w_next_state = mem_ready ? FETCH : MEMWRITE;
            EXECUTER,
            EXECUTEI: w_next_state = no_write ? FETCH : ALUWB;
            ALUWB:    w_next_state = FETCH;
            BRANCH:   w_next_state = FETCH;
            default:  w_next_state = FETCH;
        endcase
    end

    main_fsm_outputs u_outputs (
        .state (r_state),
        .ctl   (w_ctl)
    );

    assign mem_req    = w_ctl.mem_req;
    assign mem_w      = w_ctl.mem_w;
    assign adr_src    = w_ctl.adr_src;
    assign reg_w      = w_ctl.reg_w;
    assign alu_src_a  = w_ctl.alu_src_a;
    assign alu_src_b  = w_ctl.alu_src_b;
    assign result_src = w_ctl.result_src;
    assign alu_op     = w_ctl.alu_op;
    assign branch     = w_ctl.branch;
    assign state      = r_state;

    // Reset masks the ready-gated strobes so no IR/PC update can slip through while held
    assign ir_write = w_ctl.fetch & mem_ready & ~reset;
    assign next_pc  = w_ctl.fetch & mem_ready & ~reset;
    assign illegal  = w_ctl.decode & (op == 2'b11);

endmodule

`default_nettype wire

// File: tb/tb_multicycle_main_fsm.sv
// ============================================================================
// Module   : tb_multicycle_main_fsm
// Purpose  : Directed self-checking bench for multicycle_main_fsm
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_main_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] op;
    logic [5:0] funct;
    logic       no_write;
    logic       mem_ready;
    logic       mem_req;
    logic       mem_w;
    logic       adr_src;
    logic       ir_write;
    logic       next_pc;
    logic       reg_w;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic       alu_op;
    logic       branch;
    logic       illegal;
    logic [3:0] state;

    int total = 0;
    int bad   = 0;

    multicycle_main_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .no_write   (no_write),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_w      (mem_w),
        .adr_src    (adr_src),
        .ir_write   (ir_write),
        .next_pc    (next_pc),
        .reg_w      (reg_w),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .result_src (result_src),
        .alu_op     (alu_op),
        .branch     (branch),
        .illegal    (illegal),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        op        = 2'b00;
        funct     = 6'b000000;
        no_write  = 1'b0;
        mem_ready = 1'b0;
        #2;
        // Reset values
        chk("rst_state",   8'(state), 8'd0);
        chk("rst_mem_req", 8'(mem_req), 8'd1);
        chk("rst_srca",    8'(alu_src_a), 8'd1);
        chk("rst_srcb",    8'(alu_src_b), 8'd2);
        chk("rst_res",     8'(result_src), 8'd2);
        chk("rst_irw",     8'(ir_write), 8'd0);
        chk("rst_regw",    8'(reg_w), 8'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_irw_rdy", 8'(ir_write), 8'd0);
        reset = 1'b0;
        #1;
        chk("fetch_irw", 8'(ir_write), 8'd1);
        chk("fetch_npc", 8'(next_pc), 8'd1);

        // STR heading into MEMWRITE, then reset while stalled there
        op = 2'b01; funct = 6'b011000;
        tick();
        chk("str_dec", 8'(state), 8'd1);
        chk("dec_memreq", 8'(mem_req), 8'd0);
        tick();
        chk("str_madr", 8'(state), 8'd2);
        chk("madr_srcb", 8'(alu_src_b), 8'd1);
        mem_ready = 1'b0;
        tick();
        chk("str_mw_state", 8'(state), 8'd5);
        chk("str_mw_memw",  8'(mem_w), 8'd1);
        chk("str_mw_adr",   8'(adr_src), 8'd1);
        tick();
        chk("str_mw_hold", 8'(state), 8'd5);
        reset = 1'b1;
        #1;
        chk("midrst_state", 8'(state), 8'd0);
        chk("midrst_memw",  8'(mem_w), 8'd0);
        reset = 1'b0;
        #1;
        chk("post_rst_irw0", 8'(ir_write), 8'd0);
        tick();
        chk("post_rst_fetch", 8'(state), 8'd0);
        mem_ready = 1'b1;
        #1;
        chk("post_rst_irw1", 8'(ir_write), 8'd1);

        // ADD register
        op = 2'b00; funct = 6'b001000; no_write = 1'b0;
        tick();
        chk("add_dec", 8'(state), 8'd1);
        tick();
        chk("add_exr",   8'(state), 8'd6);
        chk("add_aluop", 8'(alu_op), 8'd1);
        chk("add_srcb",  8'(alu_src_b), 8'd0);
        chk("add_regw0", 8'(reg_w), 8'd0);
        tick();
        chk("add_wb",    8'(state), 8'd8);
        chk("add_regw1", 8'(reg_w), 8'd1);
        chk("add_res",   8'(result_src), 8'd0);
        tick();
        chk("add_done",  8'(state), 8'd0);
        chk("add_regw2", 8'(reg_w), 8'd0);

        // CMP immediate, no write-back
        funct = 6'b110101; no_write = 1'b1;
        tick();
        chk("cmp_dec", 8'(state), 8'd1);
        tick();
        chk("cmp_exi",   8'(state), 8'd7);
        chk("cmp_srcb",  8'(alu_src_b), 8'd1);
        chk("cmp_aluop", 8'(alu_op), 8'd1);
        chk("cmp_regw",  8'(reg_w), 8'd0);
        tick();
        chk("cmp_done", 8'(state), 8'd0);
        chk("cmp_regw2", 8'(reg_w), 8'd0);

        // LDR with two stall cycles in MEMREAD
        op = 2'b01; funct = 6'b011001; no_write = 1'b0;
        tick();
        chk("ldr_dec", 8'(state), 8'd1);
        tick();
        chk("ldr_madr", 8'(state), 8'd2);
        mem_ready = 1'b0;
        tick();
        chk("ldr_mr1", 8'(state), 8'd3);
        chk("ldr_mr1_req", 8'(mem_req), 8'd1);
        chk("ldr_mr1_adr", 8'(adr_src), 8'd1);
        tick();
        chk("ldr_mr2", 8'(state), 8'd3);
        chk("ldr_mr2_req", 8'(mem_req), 8'd1);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("ldr_mr3", 8'(state), 8'd3);
        chk("ldr_mr3_adr", 8'(adr_src), 8'd1);
        tick();
        chk("ldr_wb",   8'(state), 8'd4);
        chk("ldr_regw", 8'(reg_w), 8'd1);
        chk("ldr_res",  8'(result_src), 8'd1);
        mem_ready = 1'b0;

        // STR with a one-cycle FETCH stall
        op = 2'b01; funct = 6'b011000;
        tick();
        chk("str_fetch",  8'(state), 8'd0);
        chk("str_irw0",   8'(ir_write), 8'd0);
        tick();
        chk("str_stall",  8'(state), 8'd0);
        mem_ready = 1'b1;
        #1;
        chk("str_irw1",   8'(ir_write), 8'd1);
        tick();
        tick();
        chk("str2_madr",  8'(state), 8'd2);
        mem_ready = 1'b0;
        tick();
        chk("str2_mw",    8'(state), 8'd5);
        chk("str2_memw",  8'(mem_w), 8'd1);
        chk("str2_regw",  8'(reg_w), 8'd0);
        tick();
        mem_ready = 1'b1;
        #1;
        chk("str2_mw2",   8'(mem_w), 8'd1);
        tick();
        chk("str2_done",  8'(state), 8'd0);
        chk("str2_memw0", 8'(mem_w), 8'd0);

        // Branch, then an illegal opcode
        op = 2'b10; funct = 6'b000000;
        tick();
        chk("b_dec", 8'(state), 8'd1);
        tick();
        chk("b_state",  8'(state), 8'd9);
        chk("b_branch", 8'(branch), 8'd1);
        chk("b_srcb",   8'(alu_src_b), 8'd1);
        chk("b_aluop",  8'(alu_op), 8'd0);
        chk("b_srca",   8'(alu_src_a), 8'd0);
        tick();
        chk("b_done", 8'(state), 8'd0);
        op = 2'b11;
        chk("ill_fetch", 8'(illegal), 8'd0);
        tick();
        chk("ill_dec",   8'(state), 8'd1);
        chk("ill_pulse", 8'(illegal), 8'd1);
        tick();
        chk("ill_next",  8'(state), 8'd0);
        chk("ill_clear", 8'(illegal), 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
- Multicycle ARM control FSM; sits directly upstream of AluDecoder.
- Sequences each instruction through fetch/decode/execute/memory/writeback cycles.
- Drives datapath mux selects and write enables; produces alu_op and branch for AluDecoder; consumes its no_write.
- Owns the simple memory request/ready handshake for instruction fetch, load and store.

Parameters:
- none (state encoding lives in the package)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-high; forces state to FETCH
- op  in  2  instr[27:26]: 00 DP, 01 memory, 10 branch, 11 illegal
- funct  in  6  instr[25:20]; funct[5]=I (immediate), funct[0]=S/L
- no_write  in  1  from AluDecoder: DP result not written (CMP/CMN/TST/TEQ)
- mem_ready  in  1  memory completes current request this cycle
- mem_req  out  1  memory access requested
- mem_w  out  1  store enable, valid only with mem_req
- adr_src  out  1  0 = PC, 1 = ALU result register
- ir_write  out  1  latch instruction
- next_pc  out  1  PC update enable for sequential fetch
- reg_w  out  1  register file write
- alu_src_a  out  2  00 = Rn, 01 = PC
- alu_src_b  out  2  00 = Rm, 01 = ExtImm, 10 = constant 4
- result_src  out  2  00 = ALUOut register, 01 = read data, 10 = ALU direct
- alu_op  out  1  to AluDecoder: 1 = DP decode, 0 = add/sub-by-U
- branch  out  1  to AluDecoder and PC logic
- illegal  out  1  one-cycle pulse in DECODE when op=11
- state  out  4  current state, for debug and bench

Behaviour:
- State register: asynchronous reset to FETCH. Outputs are Moore functions of state, except ir_write and next_pc, which are also gated by mem_ready.
- Unlisted outputs in any state are 0; 2-bit fields are 00.
- Reset values are the FETCH outputs with mem_ready=0: mem_req=1, alu_src_a=01, alu_src_b=10, result_src=10, all enables 0, state=FETCH.
- FETCH:
  - mem_req=1, adr_src=0, alu_src_a=01, alu_src_b=10, result_src=10, alu_op=0.
  - ir_write = next_pc = mem_ready.
  - Next: mem_ready ? DECODE : FETCH.
- DECODE:
  - alu_src_a=01, alu_src_b=10, result_src=10 (R15 = PC+8).
  - Next: op 00 with funct[5]=1 -> EXECUTEI; op 00 with funct[5]=0 -> EXECUTER; op 01 -> MEMADR; op 10 -> BRANCH; op 11 -> FETCH with illegal=1.
- MEMADR: alu_src_a=00, alu_src_b=01, alu_op=0. Next: funct[0] ? MEMREAD : MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1, result_src=00. Next: mem_ready ? MEMWB : MEMREAD.
- MEMWB: result_src=01, reg_w=1. Next: FETCH.
- MEMWRITE: mem_req=1, mem_w=1, adr_src=1, result_src=00. Next: mem_ready ? FETCH : MEMWRITE.
- EXECUTER: alu_src_a=00, alu_src_b=00, alu_op=1. Next: no_write ? FETCH : ALUWB.
- EXECUTEI: as EXECUTER but alu_src_b=01.
- ALUWB: result_src=00, reg_w=1. Next: FETCH.
- BRANCH: alu_src_a=00, alu_src_b=01, result_src=10, alu_op=0, branch=1. Next: FETCH.
- mem_ready is ignored in states without mem_req.
- mem_ready held high continuously: no stall; each memory state lasts one cycle.
- Any unencoded state value -> FETCH on the next edge, all enables 0 meanwhile.
- Reset asserted mid-instruction: immediate return to FETCH; reg_w, mem_w, ir_write and next_pc drop to 0 without waiting for a clock.
- Cycle counts with no stalls:
  - DP with write: 4 (FETCH, DECODE, EXEC, ALUWB)
  - DP with no_write: 3
  - LDR: 5
  - STR: 4
  - B: 3
  - illegal: 2

Decomposition:
- Package ctl_pkg:
  - state_t enum (FETCH=0, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH)
  - src encodings SRCA_RN/SRCA_PC, SRCB_RM/SRCB_IMM/SRCB_FOUR, RES_ALUOUT/RES_RDATA/RES_ALU
  - op encodings OP_DP/OP_MEM/OP_BR
- One sub-module: main_fsm_outputs, a purely combinational state -> control-vector lookup. The top module keeps the state register and next-state logic.

Test Plan:
- Reset asserted mid-MEMWRITE (mem_ready=0) -> state=FETCH and mem_w=0 within the same cycle, before any edge; after release, ir_write=1 on the first cycle with mem_ready=1.
- ADD register (op=00, funct=001000), mem_ready=1 -> states 0,1,6,8,0; alu_op=1 in EXECUTER; reg_w=1 only in ALUWB.
- CMP immediate (op=00, funct=110101, no_write=1) -> states 0,1,7,0; reg_w never 1.
- LDR (op=01, funct=011001) with mem_ready low for 2 cycles in MEMREAD -> MEMREAD held 3 cycles, mem_req=1 and adr_src=1 throughout, then MEMWB with reg_w=1, result_src=01.
- STR (funct=011000) with FETCH stalled 1 cycle -> ir_write=0 then 1; MEMWRITE has mem_w=1 until mem_ready; reg_w never 1.
- B (op=10) -> BRANCH with branch=1, alu_src_b=01, alu_op=0; then op=11 -> illegal=1 for exactly one cycle in DECODE, next state FETCH.
